ifetch_unit: RTL and testbench

//  Fetch stage of the 5-stage MIPS core. Owns the PC and issues one-outstanding

---
 rtl/ifetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_ifetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit -- fetch stage of the 5-stage MIPS core.
//
// Owns the fetch PC and keeps at most one request outstanding on the
// instruction bus. A returned word goes straight to decode when it is
// accepted. Otherwise it is parked in a hold buffer until decode takes it.
// Branch redirects take effect when the delay slot leaves fetch.
// Exception redirects take effect at once. A request that is already in
// flight is drained in DROP, and its returned word is discarded.
//
// Build option:
//   FETCH_ADDR_CHECK_EN  when defined, a misaligned pcF issues no request.
//                        The stage instead presents a nop with exc_adelF=1.
//                        When undefined, ireq_addr[1:0] is forced to zero and
//                        exc_adelF is tied low.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   ireq_valid, ireq_addr           instruction request (address = pcF)
//   iresp_addr_ok                   request accepted this cycle
//   iresp_data_ok, iresp_data       response word valid this cycle
//   stallF                          decode will not accept this cycle
//   redirect_valid, redirect_pc     taken branch/jump, applied on advance
//   excp_valid, excp_pc             exception/eret redirect, highest priority
//   i_data_ok, instrF, pcF          fetched instruction and its PC
//   exc_adelF                       misaligned fetch flag
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic        i_data_ok,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic        exc_adelF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc, pend_pc_d;
  logic        pend_kill, pend_kill_d;
  logic [31:0] hold_buf;
  logic        hold_load;
  logic [31:0] next_pc, kill_pc;
  logic        misaligned, word_here, advance;

`ifdef FETCH_ADDR_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign ireq_addr  = pc_q;
`else
  assign misaligned = 1'b0;
  assign ireq_addr  = {pc_q[31:2], 2'b00};
`endif

  assign pcF        = pc_q;
  assign ireq_valid = resetn & (state == S_REQ) & ~misaligned;
  assign exc_adelF  = resetn & (state == S_REQ) & misaligned;

  // A word is available from one of four sources: the misaligned nop,
  // same-cycle grant plus data, late data in WAIT, or the hold buffer.
  always_comb begin
    word_here = 1'b0;
    unique case (state)
      S_REQ:  word_here = misaligned | (iresp_addr_ok & iresp_data_ok);
      S_WAIT: word_here = iresp_data_ok;
      S_HOLD: word_here = 1'b1;
      S_DROP: word_here = 1'b0;
    endcase
  end

  // Never show a word that is being killed, including the whole time a kill
  // is pending behind an unaccepted request.
  assign i_data_ok = resetn & word_here & ~excp_valid & ~pend_kill;
  assign advance   = i_data_ok & ~stallF;
  assign next_pc   = redirect_valid ? redirect_pc : pc_q + 32'd4;

  always_comb begin
    instrF = 32'h0;
    if (i_data_ok && !misaligned)
      instrF = (state == S_HOLD) ? hold_buf : iresp_data;
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc;
    pend_kill_d = pend_kill;
    hold_load   = 1'b0;
    // A new exception overrides a kill that is still pending.
    kill_pc     = excp_valid ? excp_pc : pend_pc;
    unique case (state)
      S_REQ: begin
        if (misaligned) begin
          if (excp_valid)   pc_d = excp_pc;
          else if (advance) pc_d = next_pc;
        end else if (excp_valid || pend_kill) begin
          // Keep the address stable until it is granted, then drain the
          // request. Grant plus data together means nothing is left to drain.
          if (iresp_addr_ok && iresp_data_ok) begin
            pc_d        = kill_pc;
            pend_kill_d = 1'b0;
          end else if (iresp_addr_ok) begin
            pend_pc_d   = kill_pc;
            pend_kill_d = 1'b0;
            state_d     = S_DROP;
          end else begin
            pend_pc_d   = kill_pc;
            pend_kill_d = 1'b1;
          end
        end else if (iresp_addr_ok) begin
          if (!iresp_data_ok) begin
            state_d = S_WAIT;
          end else if (advance) begin
            pc_d = next_pc;
          end else begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        if (iresp_data_ok) begin
          state_d = S_REQ;
          if (excp_valid) begin
            pc_d = excp_pc;
          end else if (advance) begin
            pc_d = next_pc;
          end else begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (excp_valid) begin
          pend_pc_d = excp_pc;
          state_d   = S_DROP;
        end
      end
      S_HOLD: begin
        if (excp_valid) begin
          pc_d    = excp_pc;
          state_d = S_REQ;
        end else if (advance) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (excp_valid) pend_pc_d = excp_pc;
        if (iresp_data_ok) begin
          pc_d    = kill_pc;
          state_d = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_REQ;
      pc_q      <= RESET_PC;
      pend_kill <= 1'b0;
    end else begin
      state     <= state_d;
      pc_q      <= pc_d;
      pend_kill <= pend_kill_d;
    end
  end

  // Data-only registers: their contents are qualified by state/pend_kill.
  always_ff @(posedge clk) begin
    pend_pc <= pend_pc_d;
    if (hold_load) hold_buf <= iresp_data;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] iresp_data = 32'h0;
  logic        stallF = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_pc = 32'h0;
  logic        i_data_ok;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic        exc_adelF;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_out_pc[$];
  logic [31:0] exp_out_ins[$];

  // bus model controls
  logic        grant_en = 1'b1;
  int          lat = 1;
  logic        bus_busy = 1'b0;

  ifetch_unit dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(addr_ok), .iresp_data_ok(data_ok), .iresp_data(iresp_data),
    .stallF(stallF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .i_data_ok(i_data_ok), .instrF(instrF), .pcF(pcF), .exc_adelF(exc_adelF)
  );

  always #5 clk = ~clk;

  // Bus responder: grants when enabled, returns ~addr 'lat' cycles after grant.
  initial begin
    logic        s_rst, s_req, s_data;
    logic [31:0] s_addr, raddr;
    int          cnt;
    raddr = 32'h0;
    cnt = 0;
    forever begin
      @(negedge clk);
      s_rst  = !resetn;
      s_req  = resetn & ireq_valid & addr_ok;
      s_data = data_ok;
      s_addr = ireq_addr;
      @(posedge clk);
      #2;
      if (s_rst) begin
        bus_busy = 1'b0;
      end else begin
        if (s_data) bus_busy = 1'b0;
        if (s_req) begin
          bus_busy = 1'b1;
          cnt = lat;
          raddr = s_addr;
        end
      end
      data_ok = 1'b0;
      if (bus_busy && resetn) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          data_ok = 1'b1;
          iresp_data = ~raddr;
        end
      end
      addr_ok = grant_en & ireq_valid & resetn;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (ireq_valid) begin
        checks++;
        if (bus_busy) begin
          errors++;
          $display("FAIL one_outstanding: ireq_valid=1 addr=%h while a request is in flight, required ireq_valid=0", ireq_addr);
        end
      end
      if (ireq_valid && addr_ok) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got request addr=%h, required none", ireq_addr);
        end else begin
          logic [31:0] e;
          e = exp_req.pop_front();
          if (ireq_addr !== e) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", ireq_addr, e);
          end
        end
      end
      if (i_data_ok && !stallF) begin
        checks++;
        if (exp_out_pc.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got pcF=%h instrF=%h, required none", pcF, instrF);
        end else begin
          logic [31:0] ep, ei;
          ep = exp_out_pc.pop_front();
          ei = exp_out_ins.pop_front();
          if (pcF !== ep || instrF !== ei) begin
            errors++;
            $display("FAIL out_word: got pcF=%h instrF=%h, required pcF=%h instrF=%h", pcF, instrF, ep, ei);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] ins);
    exp_out_pc.push_back(pc);
    exp_out_ins.push_back(ins);
  endtask

  task automatic drained(input string name);
    checks++;
    if (exp_req.size() != 0 || exp_out_pc.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending req=%0d out=%0d, required 0 and 0", name, exp_req.size(), exp_out_pc.size());
    end
    exp_req.delete();
    exp_out_pc.delete();
    exp_out_ins.delete();
  endtask

  // Leaves the bench at the start of the first cycle after resetn rises.
  task automatic do_reset();
    resetn = 1'b0;
    stallF = 1'b0;
    redirect_valid = 1'b0;
    excp_valid = 1'b0;
    grant_en = 1'b1;
    lat = 1;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    // Reset state, then back-to-back fetch with 1-cycle data
    resetn = 1'b0;
    cyc();
    mid();
    chk("rst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
    chk("rst_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    chk("rst_instrF", instrF, 32'h0);
    chk("rst_pcF", pcF, 32'hbfc0_0000);
    chk("rst_exc_adelF", {31'h0, exc_adelF}, 32'h0);
    cyc();
    resetn = 1'b1;
    exp_req.push_back(32'hbfc0_0000);
    exp_req.push_back(32'hbfc0_0004);
    exp_req.push_back(32'hbfc0_0008);
    push_out(32'hbfc0_0000, 32'h403f_ffff);
    push_out(32'hbfc0_0004, 32'h403f_fffb);
    repeat (5) cyc();
    drained("seq");

    // Stall for 3 cycles when the word for ...04 returns
    do_reset();
    exp_req.push_back(32'hbfc0_0000);
    exp_req.push_back(32'hbfc0_0004);
    exp_req.push_back(32'hbfc0_0008);
    push_out(32'hbfc0_0000, 32'h403f_ffff);
    push_out(32'hbfc0_0004, 32'h403f_fffb);
    repeat (3) cyc();
    stallF = 1'b1;
    mid();
    chk("stall_wait_i_data_ok", {31'h0, i_data_ok}, 32'h1);
    chk("stall_wait_ireq_valid", {31'h0, ireq_valid}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      mid();
      chk("hold_i_data_ok", {31'h0, i_data_ok}, 32'h1);
      chk("hold_ireq_valid", {31'h0, ireq_valid}, 32'h0);
      chk("hold_instrF", instrF, 32'h403f_fffb);
      chk("hold_pcF", pcF, 32'hbfc0_0004);
    end
    cyc();
    stallF = 1'b0;
    cyc();
    cyc();
    drained("stall");

    // Redirect applied on the advance cycle only
    do_reset();
    exp_req.push_back(32'hbfc0_0000);
    exp_req.push_back(32'h8000_0100);
    exp_req.push_back(32'h8000_0104);
    push_out(32'hbfc0_0000, 32'h403f_ffff);
    push_out(32'h8000_0100, 32'h7fff_feff);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    cyc();
    cyc();
    redirect_valid = 1'b0;
    repeat (2) cyc();
    cyc();
    drained("redirect");

    // Exception in WAIT, data 4 cycles late -> DROP, stale word hidden
    do_reset();
    lat = 5;
    excp_pc = 32'hbfc0_0380;
    exp_req.push_back(32'hbfc0_0000);
    exp_req.push_back(32'hbfc0_0380);
    exp_req.push_back(32'hbfc0_0384);
    push_out(32'hbfc0_0380, 32'h403f_fc7f);
    cyc();
    excp_valid = 1'b1;
    mid();
    chk("excp_wait_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    cyc();
    excp_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("drop_i_data_ok", {31'h0, i_data_ok}, 32'h0);
      chk("drop_ireq_valid", {31'h0, ireq_valid}, 32'h0);
      cyc();
    end
    mid();
    chk("drop_stale_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    repeat (3) cyc();
    cyc();
    drained("excp_wait");

    // Exception in REQ before the grant
    do_reset();
    grant_en = 1'b0;
    excp_pc = 32'hbfc0_0380;
    exp_req.push_back(32'hbfc0_0000);
    exp_req.push_back(32'hbfc0_0380);
    exp_req.push_back(32'hbfc0_0384);
    push_out(32'hbfc0_0380, 32'h403f_fc7f);
    cyc();
    excp_valid = 1'b1;
    mid();
    chk("excp_req_addr", ireq_addr, 32'hbfc0_0000);
    chk("excp_req_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    cyc();
    excp_valid = 1'b0;
    mid();
    chk("pend_kill_ireq_valid", {31'h0, ireq_valid}, 32'h1);
    chk("pend_kill_addr", ireq_addr, 32'hbfc0_0000);
    chk("pend_kill_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    cyc();
    grant_en = 1'b1;
    cyc();
    mid();
    chk("req_drop_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    repeat (3) cyc();
    cyc();
    drained("excp_req");

    // Misaligned redirect target
    do_reset();
    excp_pc = 32'hbfc0_0380;
    exp_req.push_back(32'hbfc0_0000);
`ifndef FETCH_ADDR_CHECK_EN
    exp_req.push_back(32'h8000_0100);
`endif
    exp_req.push_back(32'hbfc0_0380);
    push_out(32'hbfc0_0000, 32'h403f_ffff);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    cyc();
    cyc();
    redirect_valid = 1'b0;
    stallF = 1'b1;
    mid();
    chk("mis_pcF", pcF, 32'h8000_0102);
`ifdef FETCH_ADDR_CHECK_EN
    chk("adel_ireq_valid", {31'h0, ireq_valid}, 32'h0);
    chk("adel_i_data_ok", {31'h0, i_data_ok}, 32'h1);
    chk("adel_exc_adelF", {31'h0, exc_adelF}, 32'h1);
    chk("adel_instrF", instrF, 32'h0);
`else
    chk("mis_ireq_addr", ireq_addr, 32'h8000_0100);
    chk("mis_exc_adelF", {31'h0, exc_adelF}, 32'h0);
`endif
    cyc();
    excp_valid = 1'b1;
    mid();
    chk("mis_excp_i_data_ok", {31'h0, i_data_ok}, 32'h0);
    cyc();
    excp_valid = 1'b0;
    stallF = 1'b0;
    cyc();
    drained("misaligned");

    resetn = 1'b0;
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
